gpr_wb_arbiter: RTL and testbench
=================================

// Module: gpr_wb_arbiter
// PURPOSE
//  Writeback arbiter directly upstream of the GPR register file; drives its single write port (wr/wa/i).
//  Merges ALU results (1-cycle path, priority) with load-return data (buffered in a small FIFO).
//  Aligns and sign/zero-extends loaded bytes/halves. Starvation guard stalls the ALU when a load waits too long.
// PARAMETERS
//  TID_W      2  thread-id width; GPR write address = {tid, rd[5:0]}, TID_W+6 bits
//  LQ_DEPTH   4  load FIFO entries, power of 2, >=2
//  STARVE_MAX 8  cycles a non-empty FIFO head may lose arbitration before alu_stall asserts, >=1
//  R0_ZERO    1  1: writes to rd==0 are dropped (wr forced to 4'h0)
// PORTS
//  clk       in   1        clock, all state on rising edge
//  rst_n     in   1        reset, asynchronous, active-low
//  alu_v     in   1        ALU result valid; consumed in any cycle where alu_stall==0
//  alu_tid   in   TID_W    ALU destination thread
//  alu_rd    in   6        ALU destination register
//  alu_be    in   4        ALU byte-lane write enables
//  alu_res   in   32       ALU result
//  alu_stall out  1        registered; 1 = ALU result not consumed this cycle, producer holds it
//  ld_v      in   1        load return valid; enqueued when ld_v & ld_rdy
//  ld_rdy    out  1        = (count != LQ_DEPTH)
//  ld_tid    in   TID_W    load destination thread
//  ld_rd     in   6        load destination register
//  ld_size   in   2        0 byte, 1 half, 2/3 word
//  ld_off    in   2        byte offset within the 32-bit bus word
//  ld_sext   in   1        1 sign-extend, 0 zero-extend
//  ld_data   in   32       word-aligned bus data
//  ld_cnt    out  $clog2(LQ_DEPTH)+1  FIFO occupancy
//  wr        out  4        registered byte write enables to regfile
//  wa        out  TID_W+6  registered write address {tid, rd}
//  wd        out  32       registered write data
// BEHAVIOUR
//  Reset (rst_n=0, async): wr=0, wa=0, wd=0, alu_stall=0, FIFO emptied (ld_cnt=0, ld_rdy=1), wait counter=0.
//   Reset mid-operation discards queued loads and any pending write; nothing reaches the regfile.
//  Arbitration, evaluated per cycle on current inputs/state:
//   alu_stall==0 & alu_v       -> ALU wins; {wr,wa,wd} <= {alu_be,{alu_tid,alu_rd},alu_res} at next edge.
//   else if FIFO non-empty      -> head wins; popped; {wr,wa,wd} <= {4'hF,{tid,rd},extended data}.
//   else                        -> wr <= 0 (wa/wd hold).
//  Latency: ALU 1 cycle (alu_v at edge N -> wr valid after edge N). Load: enqueue at edge N, earliest
//   write after edge N+1 (2 cycles). No bypass around the FIFO.
//  R0_ZERO=1 & rd==0: selected entry still consumed/popped but wr <= 0.
//  Load extension applied at dequeue (FIFO stores raw fields):
//   byte: lane = ld_data[8*off+:8]; half: lane = ld_data[16*off[1]+:16], off[0] ignored; word: off ignored.
//   ld_sext=1 replicates lane MSB into upper bits, else zeros.
//  FIFO: circular, wrap-around pointers; simultaneous push+pop keeps count. ld_rdy reflects count only,
//   so a full FIFO refuses ld_v even in a pop cycle. ld_v while !ld_rdy is ignored (no overflow).
//  Starvation: wait counter increments each cycle FIFO non-empty and head not popped; clears on pop or empty.
//   When counter reaches STARVE_MAX, alu_stall <= 1 at next edge; while alu_stall=1 head wins.
//   alu_stall <= 0 at the edge where the head pops. alu_stall=1 with FIFO empty cannot occur.
//  Ordering: loads leave in arrival order; ALU-vs-load order to the same register is upstream's duty.
// TESTING
//  1 ALU: alu_v=1 tid=1 rd=5 be=F res=DEADBEEF (TID_W=2) -> next cycle wr=F wa=0x45 wd=DEADBEEF; then wr=0.
//  2 Load byte: size=0 off=2 sext=1 data=12803456 tid=0 rd=3 -> 2 cycles later wr=F wa=0x03 wd=FFFFFF80;
//    same with sext=0 -> wd=00000080; size=1 off=3 data=ABCD0000 sext=0 -> wd=0000ABCD.
//  3 Conflict: alu_v and ld_v same cycle, FIFO empty -> ALU write at +1, load write at +2, ld_cnt 1->0.
//  4 Full: alu_v held, STARVE_MAX=8, 5 back-to-back ld_v -> ld_rdy=0 after 4th, 5th dropped, ld_cnt=4;
//    release ALU -> exactly 4 load writes in order.
//  5 Starve: STARVE_MAX=3, alu_v held, one load queued -> alu_stall=1 after 3 losing cycles, load written
//    in stall cycle, alu_stall=0 next cycle, held ALU result then written once.
//  6 Edge: rd=0 with R0_ZERO=1 -> wr=0, FIFO still pops; queue 2 loads then rst_n=0 -> wr=0, ld_cnt=0, no write.

Source files
------------

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: writeback arbiter for the GPR register file write port.
// ALU results take the port whenever they are presented and not stalled.
// Load returns queue in a small FIFO and drain when the ALU is idle.
// A starvation guard stalls the ALU once the FIFO head has waited too long.
// Loads are kept raw in the FIFO and are aligned/extended on the way out.
module gpr_wb_arbiter #(
   parameter int TID_W      = 2,
   parameter int LQ_DEPTH   = 4,
   parameter int STARVE_MAX = 8,
   parameter bit R0_ZERO    = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          alu_v,
   input  logic [TID_W-1:0]              alu_tid,
   input  logic [5:0]                    alu_rd,
   input  logic [3:0]                    alu_be,
   input  logic [31:0]                   alu_res,
   output logic                          alu_stall,
   input  logic                          ld_v,
   output logic                          ld_rdy,
   input  logic [TID_W-1:0]              ld_tid,
   input  logic [5:0]                    ld_rd,
   input  logic [1:0]                    ld_size,
   input  logic [1:0]                    ld_off,
   input  logic                          ld_sext,
   input  logic [31:0]                   ld_data,
   output logic [$clog2(LQ_DEPTH):0]     ld_cnt,
   output logic [3:0]                    wr,
   output logic [TID_W+5:0]              wa,
   output logic [31:0]                   wd
);

   localparam int AW = $clog2(LQ_DEPTH);
   localparam int CW = AW + 1;
   localparam int WW = $clog2(STARVE_MAX + 1);

   typedef struct packed {
      logic [TID_W-1:0] tid;
      logic [5:0]       rd;
      logic [1:0]       size;
      logic [1:0]       off;
      logic             sext;
      logic [31:0]      data;
   } lq_entry_t;

   lq_entry_t       lq_mem [LQ_DEPTH];
   lq_entry_t       entry_in;
   lq_entry_t       head;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [WW-1:0]   wait_cnt;
   logic            fifo_empty;
   logic            alu_win;
   logic            push;
   logic            pop;
   logic            wait_hit;
   logic [31:0]     head_ext;

   // Selects the addressed lane of a bus word and extends it to 32 bits.
   function automatic logic [31:0] extend_load(
      input logic [1:0]  size,
      input logic [1:0]  off,
      input logic        sext,
      input logic [31:0] data
   );
      logic [7:0]  lane_b;
      logic [15:0] lane_h;
      logic [31:0] res;
      case (off)
         2'd0:    lane_b = data[7:0];
         2'd1:    lane_b = data[15:8];
         2'd2:    lane_b = data[23:16];
         default: lane_b = data[31:24];
      endcase
      // off[0] is irrelevant for halves; only the upper/lower half is chosen
      lane_h = off[1] ? data[31:16] : data[15:0];
      case (size)
         2'd0:    res = {{24{sext & lane_b[7]}}, lane_b};
         2'd1:    res = {{16{sext & lane_h[15]}}, lane_h};
         default: res = data;
      endcase
      return res;
   endfunction

   assign fifo_empty = (count == '0);
   assign ld_rdy     = (count != CW'(LQ_DEPTH));
   assign ld_cnt     = count;
   assign alu_win    = !alu_stall && alu_v;
   assign pop        = !alu_win && !fifo_empty;
   // A full FIFO refuses new loads even when the head pops this cycle
   assign push       = ld_v && ld_rdy;
   assign head       = lq_mem[rd_ptr];
   assign head_ext   = extend_load(head.size, head.off, head.sext, head.data);
   assign wait_hit   = (int'(wait_cnt) + 1) >= STARVE_MAX;

   // Packs the incoming load return into a FIFO entry.
   always_comb begin
      entry_in      = '0;
      entry_in.tid  = ld_tid;
      entry_in.rd   = ld_rd;
      entry_in.size = ld_size;
      entry_in.off  = ld_off;
      entry_in.sext = ld_sext;
      entry_in.data = ld_data;
   end

   // FIFO storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         lq_mem[wr_ptr] <= entry_in;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Starvation guard: count lost cycles of a waiting head, stall the ALU at the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt  <= '0;
         alu_stall <= 1'b0;
      end else if (pop || fifo_empty) begin
         wait_cnt  <= '0;
         alu_stall <= 1'b0;
      end else if (wait_hit) begin
         wait_cnt  <= WW'(STARVE_MAX);
         alu_stall <= 1'b1;
      end else begin
         wait_cnt  <= wait_cnt + WW'(1);
      end
   end

   // Registered regfile write port; wa/wd hold when nothing is written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr <= 4'h0;
         wa <= '0;
         wd <= '0;
      end else if (alu_win) begin
         wr <= (R0_ZERO && (alu_rd == 6'd0)) ? 4'h0 : alu_be;
         wa <= {alu_tid, alu_rd};
         wd <= alu_res;
      end else if (pop) begin
         wr <= (R0_ZERO && (head.rd == 6'd0)) ? 4'h0 : 4'hF;
         wa <= {head.tid, head.rd};
         wd <= head_ext;
      end else begin
         wr <= 4'h0;
      end
   end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the writeback arbiter.
module tb_gpr_wb_arbiter;

   localparam int SM = 8;

   logic        clk = 1'b0;
   logic        rst_n;

   // main instance (STARVE_MAX = 8)
   logic        alu_v;
   logic [1:0]  alu_tid;
   logic [5:0]  alu_rd;
   logic [3:0]  alu_be;
   logic [31:0] alu_res;
   logic        alu_stall;
   logic        ld_v;
   logic        ld_rdy;
   logic [1:0]  ld_tid;
   logic [5:0]  ld_rd;
   logic [1:0]  ld_size;
   logic [1:0]  ld_off;
   logic        ld_sext;
   logic [31:0] ld_data;
   logic [2:0]  ld_cnt;
   logic [3:0]  wr;
   logic [7:0]  wa;
   logic [31:0] wd;

   // short-starvation instance (STARVE_MAX = 3)
   logic        s_alu_v;
   logic [1:0]  s_alu_tid;
   logic [5:0]  s_alu_rd;
   logic [3:0]  s_alu_be;
   logic [31:0] s_alu_res;
   logic        s_alu_stall;
   logic        s_ld_v;
   logic        s_ld_rdy;
   logic [1:0]  s_ld_tid;
   logic [5:0]  s_ld_rd;
   logic [1:0]  s_ld_size;
   logic [1:0]  s_ld_off;
   logic        s_ld_sext;
   logic [31:0] s_ld_data;
   logic [2:0]  s_ld_cnt;
   logic [3:0]  s_wr;
   logic [7:0]  s_wa;
   logic [31:0] s_wd;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   gpr_wb_arbiter #(.TID_W(2), .LQ_DEPTH(4), .STARVE_MAX(SM), .R0_ZERO(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .alu_v(alu_v), .alu_tid(alu_tid), .alu_rd(alu_rd), .alu_be(alu_be), .alu_res(alu_res),
      .alu_stall(alu_stall),
      .ld_v(ld_v), .ld_rdy(ld_rdy), .ld_tid(ld_tid), .ld_rd(ld_rd), .ld_size(ld_size),
      .ld_off(ld_off), .ld_sext(ld_sext), .ld_data(ld_data), .ld_cnt(ld_cnt),
      .wr(wr), .wa(wa), .wd(wd)
   );

   gpr_wb_arbiter #(.TID_W(2), .LQ_DEPTH(4), .STARVE_MAX(3), .R0_ZERO(1'b1)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .alu_v(s_alu_v), .alu_tid(s_alu_tid), .alu_rd(s_alu_rd), .alu_be(s_alu_be),
      .alu_res(s_alu_res), .alu_stall(s_alu_stall),
      .ld_v(s_ld_v), .ld_rdy(s_ld_rdy), .ld_tid(s_ld_tid), .ld_rd(s_ld_rd),
      .ld_size(s_ld_size), .ld_off(s_ld_off), .ld_sext(s_ld_sext), .ld_data(s_ld_data),
      .ld_cnt(s_ld_cnt), .wr(s_wr), .wa(s_wa), .wd(s_wd)
   );

   // ---------------- reference model ----------------
   typedef struct {
      logic [1:0]  tid;
      logic [5:0]  rd;
      logic [1:0]  size;
      logic [1:0]  off;
      logic        sext;
      logic [31:0] data;
   } ld_t;

   ld_t         mq[$];
   int          m_wait;
   bit          m_stall;
   logic [3:0]  m_wr;
   logic [7:0]  m_wa;
   logic [31:0] m_wd;

   function automatic logic [31:0] ref_ext(input ld_t e);
      logic [31:0] v;
      if (e.size == 2'd0) begin
         v = (e.data >> (8 * e.off)) & 32'h0000_00FF;
         if (e.sext && v[7]) v = v | 32'hFFFF_FF00;
      end else if (e.size == 2'd1) begin
         v = (e.data >> (e.off[1] ? 16 : 0)) & 32'h0000_FFFF;
         if (e.sext && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = e.data;
      end
      return v;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_wait  = 0;
      m_stall = 0;
      m_wr    = 4'h0;
      m_wa    = 8'h00;
      m_wd    = 32'h0;
   endtask

   // Advances the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      int  pre;
      bit  popped;
      ld_t h;
      ld_t e;
      pre    = mq.size();
      popped = 0;
      if (!m_stall && alu_v) begin
         m_wr = (alu_rd == 6'd0) ? 4'h0 : alu_be;
         m_wa = {alu_tid, alu_rd};
         m_wd = alu_res;
      end else if (pre > 0) begin
         h      = mq.pop_front();
         popped = 1;
         m_wr   = (h.rd == 6'd0) ? 4'h0 : 4'hF;
         m_wa   = {h.tid, h.rd};
         m_wd   = ref_ext(h);
      end else begin
         m_wr = 4'h0;
      end
      if (ld_v && pre < 4) begin
         e.tid = ld_tid; e.rd = ld_rd; e.size = ld_size;
         e.off = ld_off; e.sext = ld_sext; e.data = ld_data;
         mq.push_back(e);
      end
      if (popped || pre == 0) begin
         m_wait  = 0;
         m_stall = 0;
      end else begin
         m_wait = m_wait + 1;
         if (m_wait >= SM) m_stall = 1;
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".wr"},    32'(wr),        32'(m_wr));
      chk({tag, ".wa"},    32'(wa),        32'(m_wa));
      chk({tag, ".wd"},    wd,             m_wd);
      chk({tag, ".cnt"},   32'(ld_cnt),    32'(mq.size()));
      chk({tag, ".rdy"},   32'(ld_rdy),    32'(mq.size() != 4));
      chk({tag, ".stall"}, 32'(alu_stall), 32'(m_stall));
   endtask

   task automatic cyc(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic set_ld(input logic [1:0] tid, input logic [5:0] rd, input logic [1:0] size,
                         input logic [1:0] off, input logic sext, input logic [31:0] data);
      ld_tid = tid; ld_rd = rd; ld_size = size; ld_off = off; ld_sext = sext; ld_data = data;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      alu_v = 0; alu_tid = 0; alu_rd = 0; alu_be = 0; alu_res = 0;
      ld_v = 0; ld_tid = 0; ld_rd = 0; ld_size = 0; ld_off = 0; ld_sext = 0; ld_data = 0;
      s_alu_v = 0; s_alu_tid = 0; s_alu_rd = 0; s_alu_be = 0; s_alu_res = 0;
      s_ld_v = 0; s_ld_tid = 0; s_ld_rd = 0; s_ld_size = 0; s_ld_off = 0; s_ld_sext = 0;
      s_ld_data = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst.wr",    32'(wr), 32'h0);
      chk("rst.wa",    32'(wa), 32'h0);
      chk("rst.wd",    wd, 32'h0);
      chk("rst.cnt",   32'(ld_cnt), 32'h0);
      chk("rst.rdy",   32'(ld_rdy), 32'h1);
      chk("rst.stall", 32'(alu_stall), 32'h0);
      rst_n = 1'b1;

      // 1: single ALU write
      alu_v = 1; alu_tid = 2'd1; alu_rd = 6'd5; alu_be = 4'hF; alu_res = 32'hDEAD_BEEF;
      cyc("t1");
      chk("t1.wr_c", 32'(wr), 32'hF);
      chk("t1.wa_c", 32'(wa), 32'h45);
      chk("t1.wd_c", wd, 32'hDEAD_BEEF);
      alu_v = 0;
      cyc("t1b");
      chk("t1b.wr_c", 32'(wr), 32'h0);

      // 2: load extension cases, two-cycle latency
      set_ld(2'd0, 6'd3, 2'd0, 2'd2, 1'b1, 32'h1280_3456);
      ld_v = 1; cyc("t2a0"); ld_v = 0;
      chk("t2a.cnt_c", 32'(ld_cnt), 32'd1);
      chk("t2a.wr0_c", 32'(wr), 32'h0);
      cyc("t2a1");
      chk("t2a.wr_c", 32'(wr), 32'hF);
      chk("t2a.wa_c", 32'(wa), 32'h03);
      chk("t2a.wd_c", wd, 32'hFFFF_FF80);
      set_ld(2'd0, 6'd3, 2'd0, 2'd2, 1'b0, 32'h1280_3456);
      ld_v = 1; cyc("t2b0"); ld_v = 0; cyc("t2b1");
      chk("t2b.wd_c", wd, 32'h0000_0080);
      set_ld(2'd0, 6'd3, 2'd1, 2'd3, 1'b0, 32'hABCD_0000);
      ld_v = 1; cyc("t2c0"); ld_v = 0; cyc("t2c1");
      chk("t2c.wd_c", wd, 32'h0000_ABCD);

      // 3: ALU and load in the same cycle
      alu_v = 1; alu_tid = 2'd2; alu_rd = 6'd10; alu_be = 4'h3; alu_res = 32'hCAFE_0001;
      set_ld(2'd1, 6'd4, 2'd2, 2'd1, 1'b1, 32'h5566_7788);
      ld_v = 1;
      cyc("t3a");
      chk("t3a.wa_c", 32'(wa), 32'h8A);
      chk("t3a.cnt_c", 32'(ld_cnt), 32'd1);
      alu_v = 0; ld_v = 0;
      cyc("t3b");
      chk("t3b.wa_c", 32'(wa), 32'h44);
      chk("t3b.wd_c", wd, 32'h5566_7788);
      chk("t3b.cnt_c", 32'(ld_cnt), 32'd0);

      // 4: fill the FIFO behind a busy ALU, fifth load refused
      alu_v = 1; alu_tid = 2'd0; alu_rd = 6'd1; alu_be = 4'hF; alu_res = 32'h100;
      for (int i = 0; i < 5; i++) begin
         set_ld(2'd0, 6'(16 + i), 2'd2, 2'd0, 1'b0, 32'(i * 32'h1111));
         ld_v = 1;
         cyc("t4fill");
         chk("t4.cnt_c", 32'(ld_cnt), 32'((i + 1 < 4) ? i + 1 : 4));
         chk("t4.rdy_c", 32'(ld_rdy), 32'(i + 1 < 4));
      end
      alu_v = 0; ld_v = 0;
      for (int i = 0; i < 4; i++) begin
         cyc("t4drain");
         chk("t4.wr_c", 32'(wr), 32'hF);
         chk("t4.wa_c", 32'(wa), 32'(16 + i));
         chk("t4.wd_c", wd, 32'(i * 32'h1111));
      end
      cyc("t4end");
      chk("t4end.wr_c", 32'(wr), 32'h0);

      // 5: starvation on the STARVE_MAX=3 instance
      s_alu_v = 1; s_alu_tid = 2'd0; s_alu_rd = 6'd7; s_alu_be = 4'hF; s_alu_res = 32'd1;
      s_ld_v = 1; s_ld_tid = 2'd0; s_ld_rd = 6'd9; s_ld_size = 2'd2; s_ld_data = 32'h1122_3344;
      @(posedge clk); #1;
      chk("t5.wd1", s_wd, 32'd1);
      chk("t5.cnt1", 32'(s_ld_cnt), 32'd1);
      s_ld_v = 0;
      for (int k = 2; k <= 4; k++) begin
         s_alu_res = 32'(k);
         @(posedge clk); #1;
         chk("t5.wd_lose", s_wd, 32'(k));
         chk("t5.stall_lose", 32'(s_alu_stall), 32'(k == 4));
      end
      s_alu_res = 32'd5;
      @(posedge clk); #1;
      chk("t5.ld_wr", 32'(s_wr), 32'hF);
      chk("t5.ld_wa", 32'(s_wa), 32'h09);
      chk("t5.ld_wd", s_wd, 32'h1122_3344);
      chk("t5.stall_clr", 32'(s_alu_stall), 32'h0);
      chk("t5.cnt0", 32'(s_ld_cnt), 32'd0);
      @(posedge clk); #1;
      chk("t5.alu_wd", s_wd, 32'd5);
      chk("t5.alu_wa", 32'(s_wa), 32'h07);
      s_alu_v = 0;
      @(posedge clk); #1;
      chk("t5.idle_wr", 32'(s_wr), 32'h0);

      // 6: rd==0 dropped, then reset with loads queued
      set_ld(2'd3, 6'd0, 2'd2, 2'd0, 1'b0, 32'h7777_0000);
      ld_v = 1; cyc("t6a0"); ld_v = 0;
      cyc("t6a1");
      chk("t6.r0_wr", 32'(wr), 32'h0);
      chk("t6.r0_cnt", 32'(ld_cnt), 32'd0);
      alu_v = 1; alu_tid = 2'd1; alu_rd = 6'd2; alu_be = 4'hF; alu_res = 32'h2222;
      set_ld(2'd1, 6'd7, 2'd2, 2'd0, 1'b0, 32'hA);
      ld_v = 1; cyc("t6q0");
      set_ld(2'd1, 6'd8, 2'd2, 2'd0, 1'b0, 32'hB);
      cyc("t6q1");
      chk("t6.q_cnt", 32'(ld_cnt), 32'd2);
      alu_v = 0; ld_v = 0;
      #2 rst_n = 1'b0;
      #1;
      chk("t6.rst_wr", 32'(wr), 32'h0);
      chk("t6.rst_cnt", 32'(ld_cnt), 32'd0);
      chk("t6.rst_rdy", 32'(ld_rdy), 32'h1);
      chk("t6.rst_wa", 32'(wa), 32'h0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc("t6post");
      chk("t6.post_wr", 32'(wr), 32'h0);

      // randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         if (!m_stall) begin
            alu_v   = ($urandom_range(0, 99) < 60);
            alu_tid = 2'($urandom);
            alu_rd  = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom);
            alu_be  = 4'($urandom);
            alu_res = $urandom;
         end
         ld_v    = ($urandom_range(0, 99) < 50);
         ld_tid  = 2'($urandom);
         ld_rd   = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom);
         ld_size = 2'($urandom);
         ld_off  = 2'($urandom);
         ld_sext = 1'($urandom);
         ld_data = $urandom;
         cyc("rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
